// File: rtl/zet_pic_pkg.sv
// rtl/zet_pic_pkg.sv - shared register map, reset values and FSM encoding for zet_pic
package zet_pic_pkg;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_IMR  = 2'd1;
  localparam logic [1:0] ADDR_BASE = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  localparam logic [7:0] IMR_RST  = 8'hFF;
  localparam logic [4:0] BASE_RST = 5'b00001;
  localparam int         EOI_BIT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ACK  = 2'b10
  } pic_state_e;

  function automatic logic [7:0] idx_mask(input logic [2:0] idx, input logic en);
    return en ? (8'h01 << idx) : 8'h00;
  endfunction

endpackage

// File: rtl/zet_pic_prio.sv
// rtl/zet_pic_prio.sv - fixed-priority encoder, bit 0 highest
module zet_pic_prio (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zet_pic.sv
// rtl/zet_pic.sv - 8-input edge-triggered priority interrupt controller
module zet_pic
  import zet_pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  output logic       intr,
  input  logic       inta,
  output logic [7:0] vector,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o
);

  logic [7:0] sync1_q, sync2_q, dly_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic [4:0] base_q, base_d;
  logic [7:0] vector_q, vector_d;
  logic [7:0] dat_q, dat_d;
  logic       intr_q;
  pic_state_e state_q, state_d;

  logic [7:0] irq_edge;
  logic [7:0] pending;
  logic [2:0] pend_idx, isr_idx;
  logic       pend_v, isr_v;
  logic       qual, ack, eoi;
  logic [7:0] ack_mask, eoi_mask;

  assign irq_edge = sync2_q & ~dly_q;
  assign pending  = irr_q & ~imr_q;

  zet_pic_prio u_prio_pend (
    .req_i   (pending),
    .idx_o   (pend_idx),
    .valid_o (pend_v)
  );

  zet_pic_prio u_prio_isr (
    .req_i   (isr_q),
    .idx_o   (isr_idx),
    .valid_o (isr_v)
  );

  // A request must strictly outrank everything in service to interrupt it.
  assign qual     = pend_v & (~isr_v | (pend_idx < isr_idx));
  assign ack      = inta & qual;
  assign eoi      = wr & (addr == ADDR_CMD) & dat_i[EOI_BIT];
  assign ack_mask = idx_mask(pend_idx, ack);
  assign eoi_mask = idx_mask(isr_idx, eoi & isr_v);

  always_comb begin
    irr_d    = (irr_q & ~ack_mask) | irq_edge;
    isr_d    = (isr_q & ~eoi_mask) | ack_mask;
    imr_d    = imr_q;
    base_d   = base_q;
    vector_d = vector_q;
    dat_d    = dat_q;
    if (wr && addr == ADDR_IMR)  imr_d  = dat_i;
    if (wr && addr == ADDR_BASE) base_d = dat_i[7:3];
    if (inta) vector_d = {base_q, ack ? pend_idx : 3'd7};
    if (rd) begin
      case (addr)
        ADDR_CMD:  dat_d = irr_q;
        ADDR_IMR:  dat_d = imr_q;
        ADDR_BASE: dat_d = {base_q, 3'b000};
        default:   dat_d = isr_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (qual) state_d = ST_REQ;
      ST_REQ:  if (inta) state_d = ST_ACK;
               else if (!qual) state_d = ST_IDLE;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Any acknowledge outside ACK lands in ACK if real, IDLE if spurious.
    if (inta) state_d = (ack && state_q != ST_ACK) ? ST_ACK : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      dly_q    <= 8'h00;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      imr_q    <= IMR_RST;
      base_q   <= BASE_RST;
      vector_q <= 8'h00;
      dat_q    <= 8'h00;
      intr_q   <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      sync1_q  <= irq;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      base_q   <= base_d;
      vector_q <= vector_d;
      dat_q    <= dat_d;
      intr_q   <= (state_d == ST_REQ);
      state_q  <= state_d;
    end
  end

  assign intr   = intr_q;
  assign vector = vector_q;
  assign dat_o  = dat_q;

endmodule

// File: tb/tb_zet_pic.sv
// tb/tb_zet_pic.sv - directed and randomized checks of zet_pic against a register-level model
module tb_zet_pic;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       intr;
  logic       inta;
  logic [7:0] vector;
  logic [1:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] dat_i;
  logic [7:0] dat_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_base;

  zet_pic dut (
    .clk    (clk),
    .rst    (rst),
    .irq    (irq),
    .intr   (intr),
    .inta   (inta),
    .vector (vector),
    .addr   (addr),
    .wr     (wr),
    .rd     (rd),
    .dat_i  (dat_i),
    .dat_o  (dat_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  function automatic int prio8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic m_qual();
    int p;
    int s;
    p = prio8(m_irr & ~m_imr);
    s = prio8(m_isr);
    return (p < 8) && (p < s);
  endfunction

  function automatic logic [7:0] bit_of(input int n);
    logic [7:0] one;
    one = 8'h01;
    return (n < 8) ? (one << n) : 8'h00;
  endfunction

  task automatic model_reset();
    m_irr  = 8'h00;
    m_isr  = 8'h00;
    m_imr  = 8'hFF;
    m_base = 5'b00001;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (3) tick();
    chk("intr_settled", {7'd0, intr}, {7'd0, m_qual()});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    dat_i = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
    case (a)
      2'd0: if (d[5]) m_isr = m_isr & ~bit_of(prio8(m_isr));
      2'd1: m_imr = d;
      2'd2: m_base = d[7:3];
      default: ;
    endcase
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    rd   = 1'b1;
    tick();
    rd   = 1'b0;
    v    = dat_o;
  endtask

  task automatic check_regs();
    logic [7:0] v;
    rd_reg(2'd0, v); chk("irr", v, m_irr);
    rd_reg(2'd1, v); chk("imr", v, m_imr);
    rd_reg(2'd2, v); chk("base", v, {m_base, 3'b000});
    rd_reg(2'd3, v); chk("isr", v, m_isr);
  endtask

  task automatic pulse_irq(input logic [7:0] r);
    irq = r;
    repeat (5) tick();
    irq = 8'h00;
    repeat (2) tick();
    m_irr = m_irr | r;
  endtask

  task automatic do_inta();
    logic [7:0] exp_v;
    logic       q;
    int         n;
    q = m_qual();
    n = prio8(m_irr & ~m_imr);
    exp_v = q ? {m_base, 3'(n)} : {m_base, 3'd7};
    inta = 1'b1;
    tick();
    inta = 1'b0;
    chk("vector", vector, exp_v);
    chk("intr_after_inta", {7'd0, intr}, 8'h00);
    if (q) begin
      m_irr = m_irr & ~bit_of(n);
      m_isr = m_isr | bit_of(n);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] r;
    int         n;
    logic [7:0] eoi_m;

    rst = 1'b0; irq = 8'h00; inta = 1'b0; addr = 2'd0; wr = 1'b0; rd = 1'b0; dat_i = 8'h00;
    model_reset();
    repeat (2) tick();
    chk("rst_intr", {7'd0, intr}, 8'h00);
    chk("rst_vector", vector, 8'h00);
    chk("rst_dat_o", dat_o, 8'h00);
    rst = 1'b1;
    tick();
    check_regs();
    chk("rst_base_const", {m_base, 3'b000}, 8'h08);

    // Basic latency: IRR at E2, intr at E3, acknowledge with reset base.
    wr_reg(2'd1, 8'hFE);
    settle();
    irq = 8'h01;
    tick();
    tick();
    addr = 2'd0; rd = 1'b1;
    tick();
    chk("irr_before_e2", dat_o, 8'h00);
    chk("intr_at_e2", {7'd0, intr}, 8'h00);
    tick();
    rd = 1'b0;
    chk("irr_at_e2", dat_o, 8'h01);
    chk("intr_at_e3", {7'd0, intr}, 8'h01);
    irq = 8'h00;
    m_irr = 8'h01;
    do_inta();
    chk("vec_030", vector, 8'h08);
    rd_reg(2'd3, v); chk("isr_030", v, 8'h01);
    wr_reg(2'd0, 8'h20);
    settle();

    // Two simultaneous requests, nesting blocked until EOI.
    wr_reg(2'd2, 8'h70);
    wr_reg(2'd1, 8'h00);
    settle();
    pulse_irq(8'h28);
    settle();
    do_inta();
    chk("vec_031a", vector, 8'h73);
    settle();
    chk("intr_blocked_031", {7'd0, intr}, 8'h00);
    wr_reg(2'd0, 8'h20);
    settle();
    chk("intr_after_eoi_031", {7'd0, intr}, 8'h01);
    do_inta();
    chk("vec_031b", vector, 8'h75);
    wr_reg(2'd0, 8'h20);
    settle();

    // Preemption by higher priority, blocking of lower priority.
    pulse_irq(8'h04);
    do_inta();
    settle();
    rd_reg(2'd3, v); chk("isr_032", v, 8'h04);
    pulse_irq(8'h02);
    settle();
    chk("intr_preempt", {7'd0, intr}, 8'h01);
    do_inta();
    chk("vec_032a", vector, 8'h71);
    wr_reg(2'd0, 8'h20);
    settle();
    pulse_irq(8'h40);
    settle();
    chk("intr_lowprio_blocked", {7'd0, intr}, 8'h00);
    wr_reg(2'd0, 8'h20);
    settle();
    do_inta();
    chk("vec_032b", vector, 8'h76);
    wr_reg(2'd0, 8'h20);
    settle();

    // Masking withdraws a request; spurious acknowledge; unmask re-raises.
    pulse_irq(8'h10);
    settle();
    wr_reg(2'd1, 8'hFF);
    tick();
    chk("intr_masked_drop", {7'd0, intr}, 8'h00);
    settle();
    do_inta();
    chk("vec_spurious", vector, 8'h77);
    check_regs();
    wr_reg(2'd1, 8'h00);
    settle();
    chk("intr_unmasked", {7'd0, intr}, 8'h01);
    do_inta();
    chk("vec_033", vector, 8'h74);
    wr_reg(2'd0, 8'h20);
    settle();

    // EOI and acknowledge in the same cycle.
    pulse_irq(8'h02);
    do_inta();
    settle();
    pulse_irq(8'h01);
    settle();
    n = prio8(m_irr & ~m_imr);
    eoi_m = bit_of(prio8(m_isr));
    addr = 2'd0; dat_i = 8'h20; wr = 1'b1; inta = 1'b1;
    tick();
    wr = 1'b0; inta = 1'b0;
    m_isr = (m_isr & ~eoi_m) | bit_of(n);
    m_irr = m_irr & ~bit_of(n);
    chk("vec_034", vector, 8'h70);
    rd_reg(2'd3, v); chk("isr_034", v, 8'h01);
    chk("isr_034_model", v, m_isr);
    wr_reg(2'd0, 8'h20);
    settle();

    // New edge on a bit in the same cycle it is acknowledged: it stays pending.
    pulse_irq(8'h01);
    settle();
    irq = 8'h01;
    tick();
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0;
    irq = 8'h00;
    chk("vec_022", vector, 8'h70);
    m_isr = m_isr | 8'h01;
    tick();
    tick();
    check_regs();
    settle();
    wr_reg(2'd0, 8'h20);
    settle();
    do_inta();
    wr_reg(2'd0, 8'h20);
    settle();

    // Asynchronous reset while requesting, spurious inta right after release.
    pulse_irq(8'h10);
    settle();
    chk("intr_before_rst", {7'd0, intr}, 8'h01);
    rst = 1'b0;
    #1;
    chk("async_rst_intr", {7'd0, intr}, 8'h00);
    chk("async_rst_vector", vector, 8'h00);
    chk("async_rst_dat_o", dat_o, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    inta = 1'b1;
    tick();
    inta = 1'b0;
    chk("vec_after_rst", vector, 8'h0F);
    check_regs();
    settle();

    // Randomized operation mix against the model.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          r = bit_of($urandom_range(0, 7));
          if ($urandom_range(0, 1) == 1) r = r | bit_of($urandom_range(0, 7));
          pulse_irq(r);
        end
        1: wr_reg(2'd1, 8'($urandom) & 8'($urandom));
        2: wr_reg(2'd0, 8'h20);
        3: do_inta();
        4: wr_reg(2'd2, 8'($urandom));
        default: wr_reg(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, 8'($urandom) & 8'hDF);
      endcase
      settle();
      if ((it % 8) == 7) check_regs();
    end
    check_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zet_pic.md
ZET_PIC -- requirements
Module: zet_pic

Interface
REQ-001 Parameters: none; reset values and register addresses SHALL be constants in the shared defines include.
REQ-002 clk  input  1  single system clock; all state on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset (low = reset).
REQ-004 irq  input  8  external interrupt lines, asynchronous; rising-edge triggered; irq[0] highest priority.
REQ-005 intr  output  1  interrupt request to CPU, registered.
REQ-006 inta  input  1  one-cycle acknowledge pulse from CPU.
REQ-007 vector  output  8  vector of last acknowledged interrupt, registered, held until next inta.
REQ-008 addr  input  2  register select.
REQ-009 wr  input  1  register write strobe, one cycle.
REQ-010 rd  input  1  register read strobe, one cycle.
REQ-011 dat_i  input  8  write data.
REQ-012 dat_o  output  8  read data, registered.

Function
REQ-013 Each irq bit SHALL pass a 2-flop synchronizer plus a delay flop; IRR bit set when synced=1 and delayed=0.
REQ-014 irq first sampled high at edge E0 SHALL set the IRR bit at E2; intr SHALL rise at E3 if the request qualifies.
REQ-015 Qualifying request: highest-priority bit of (IRR & ~IMR) with index strictly lower than the highest-priority ISR bit (any index if ISR=0).
REQ-016 FSM states IDLE, REQ, ACK; intr=1 only in REQ.
REQ-017 IDLE->REQ when a qualifying request exists; REQ->IDLE when none remains (e.g. IMR write) and inta=0; REQ->ACK on inta; ACK->IDLE unconditionally after one cycle.
REQ-018 On inta with request index n: clear IRR[n], set ISR[n], vector <= {base[7:3], n}; intr low the next cycle.
REQ-019 On inta with no qualifying request (spurious, any state): vector <= {base[7:3], 3'd7}; IRR and ISR unchanged; state -> IDLE.
REQ-020 Writes: addr0 with dat_i[5]=1 = non-specific EOI (clear highest-priority ISR bit; no-op if ISR=0); addr1 -> IMR <= dat_i; addr2 -> base[7:3] <= dat_i[7:3]; addr3 ignored.
REQ-021 Reads: dat_o valid the cycle after rd; addr0 IRR, addr1 IMR, addr2 {base[7:3],3'b000}, addr3 ISR; dat_o holds otherwise.
REQ-022 Same-cycle edge and inta on same IRR bit: set wins (bit stays 1).
REQ-023 Same-cycle EOI and inta: ISR_next = (ISR & ~eoi_mask) | ack_mask, eoi_mask from current ISR.
REQ-024 Same-cycle IMR write and inta: acknowledge evaluated with old IMR.
REQ-025 Masked IRR bits SHALL stay latched and raise intr once unmasked.

Reset
REQ-026 rst low SHALL immediately force: IRR=0, ISR=0, IMR=8'hFF, base=5'b00001 (vector base 8'h08), intr=0, vector=0, dat_o=0, synchronizer/delay flops=0, state IDLE.
REQ-027 Reset mid-handshake SHALL drop intr at once; a pulse on inta in the first cycle after release SHALL be treated as spurious.

Structure
REQ-028 Register addresses, IMR/base reset values and FSM state encodings SHALL live in the shared defines include.
REQ-029 One sub-module zet_pic_prio: 8-bit in -> 3-bit index + valid, fixed priority bit0 highest; instantiated for pending and ISR.

Verification
REQ-030 Reset, write IMR=8'hFE, pulse irq[0] at E0 -> IRR=8'h01 at E2, intr=1 at E3; inta -> vector=8'h08, ISR=8'h01, intr=0 next cycle.
REQ-031 base write 8'h70, IMR=0, irq[3] and irq[5] rise same cycle -> first inta vector=8'h73, intr re-asserts only after EOI, second inta vector=8'h75.
REQ-032 ISR=8'h04 in service, irq[1] rises -> intr=1 (preempts); irq[6] rises -> no intr until EOI clears ISR[2].
REQ-033 intr high on irq[4], write IMR=8'hFF before inta -> intr low next cycle; later inta -> vector={base,3'd7}, ISR unchanged.
REQ-034 EOI write and inta same cycle with ISR=8'h02, request irq[0] -> ISR=8'h01 after cycle.
REQ-035 rst low while state REQ -> intr=0, IMR=8'hFF, IRR=0 same cycle, no clock edge required.
